// File: rtl/toggle_pkg.sv
// Shared constants and types for the toggle-encoded event link.
package toggle_pkg;

    // Default synchronizer depth on the asynchronous toggle line.
    localparam int unsigned SYNC_STAGES_DEF = 2;

    // Default width of the pending-event counter.
    localparam int unsigned CNT_W_DEF = 4;

    // Receiver control state: settle the synchronizer, then decode edges.
    typedef enum logic {
        WARMUP = 1'b0,
        RUN    = 1'b1
    } rx_state_e;

endpackage : toggle_pkg

// File: rtl/sync_chain.sv
// Multi-flop synchronizer for a single asynchronous level.
// Shared between the toggle receiver and the matching transmitter.
module sync_chain #(
    parameter int unsigned DEPTH = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic [DEPTH-1:0] sync_q;
    logic [DEPTH-1:0] sync_d;

    // Shift the incoming level one stage deeper each clock.
    always_comb begin
        sync_d = {sync_q[DEPTH-2:0], d_i};
    end

    // Synchronizer flops, cleared by the synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q_o = sync_q[DEPTH-1];

endmodule : sync_chain

// File: rtl/toggle_event_rx.sv
// Receiver for a toggle-encoded event line: synchronizes the remote level,
// turns every level change into one event and queues events in a saturating
// counter that a valid/ready consumer drains one at a time.
module toggle_event_rx
    import toggle_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int unsigned CNT_W       = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tgl_in,
    input  logic             evt_ready,
    input  logic             clr_ovf,
    output logic             evt_valid,
    output logic [CNT_W-1:0] pend_cnt,
    output logic             overflow,
    output logic             armed
);

    // Warm-up counter must reach SYNC_STAGES+1.
    localparam int unsigned      WU_W    = $clog2(SYNC_STAGES + 2);
    localparam logic [WU_W-1:0]  WU_LAST = WU_W'(SYNC_STAGES);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    rx_state_e        state_q;
    rx_state_e        state_d;
    logic [WU_W-1:0]  wu_cnt_q;
    logic [WU_W-1:0]  wu_cnt_d;
    logic             armed_q;
    logic             armed_d;

    logic             sync_out;
    logic             prev_q;
    logic             prev_d;
    logic [CNT_W-1:0] pend_q;
    logic [CNT_W-1:0] pend_d;
    logic             evt_valid_q;
    logic             evt_valid_d;
    logic             overflow_q;
    logic             overflow_d;

    logic             edge_c;
    logic             accept_c;
    logic             ovf_set_c;

    // Bring the asynchronous toggle level into the clk domain.
    sync_chain #(
        .DEPTH (SYNC_STAGES)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (tgl_in),
        .q_o (sync_out)
    );

    // Control state and warm-up counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= WARMUP;
            wu_cnt_q <= '0;
            armed_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            wu_cnt_q <= wu_cnt_d;
            armed_q  <= armed_d;
        end
    end

    // Warm-up sequencing: count SYNC_STAGES+1 clocks, then decode forever.
    always_comb begin
        state_d  = state_q;
        wu_cnt_d = wu_cnt_q;
        armed_d  = 1'b0;
        case (state_q)
            WARMUP: begin
                wu_cnt_d = wu_cnt_q + WU_W'(1);
                if (wu_cnt_q == WU_LAST) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                state_d = RUN;
                armed_d = 1'b1;
            end
            default: begin
                state_d = WARMUP;
            end
        endcase
    end

    // Event datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q      <= 1'b0;
            pend_q      <= '0;
            evt_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            prev_q      <= prev_d;
            pend_q      <= pend_d;
            evt_valid_q <= evt_valid_d;
            overflow_q  <= overflow_d;
        end
    end

    // Edge decode, saturating pending count and sticky overflow.
    always_comb begin
        prev_d    = sync_out;
        pend_d    = pend_q;
        ovf_set_c = 1'b0;
        edge_c    = (state_q == RUN) && (sync_out ^ prev_q);
        accept_c  = evt_valid_q && evt_ready;

        // An edge and an accept in the same clock cancel out.
        if (edge_c && !accept_c) begin
            if (pend_q == CNT_MAX) begin
                ovf_set_c = 1'b1;
            end else begin
                pend_d = pend_q + CNT_W'(1);
            end
        end else if (!edge_c && accept_c) begin
            pend_d = pend_q - CNT_W'(1);
        end

        evt_valid_d = (pend_d != '0);

        // A saturating edge takes priority over a clear in the same clock.
        if (ovf_set_c) begin
            overflow_d = 1'b1;
        end else if (clr_ovf) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end
    end

    assign evt_valid = evt_valid_q;
    assign pend_cnt  = pend_q;
    assign overflow  = overflow_q;
    assign armed     = armed_q;

endmodule : toggle_event_rx

// File: tb/tb_toggle_event_rx.sv
// Directed bench for toggle_event_rx with SYNC_STAGES=2, CNT_W=4.
module tb_toggle_event_rx;

    localparam int unsigned S = 2;
    localparam int unsigned W = 4;

    logic         clk;
    logic         rst;
    logic         tgl_in;
    logic         evt_ready;
    logic         clr_ovf;
    logic         evt_valid;
    logic [W-1:0] pend_cnt;
    logic         overflow;
    logic         armed;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic tgl;
        logic rdy;
        int   ticks;
        logic exp_valid;
        int   exp_cnt;
        logic exp_ovf;
        logic exp_armed;
    } vec_t;

    localparam int NVEC = 9;
    vec_t vecs [NVEC];

    toggle_event_rx #(
        .SYNC_STAGES (S),
        .CNT_W       (W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .tgl_in    (tgl_in),
        .evt_ready (evt_ready),
        .clr_ovf   (clr_ovf),
        .evt_valid (evt_valid),
        .pend_cnt  (pend_cnt),
        .overflow  (overflow),
        .armed     (armed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n rising edges, leaving time 1 unit past the last edge.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input logic v, input int c, input logic o, input logic a);
        chk({tag, ".evt_valid"}, 32'(evt_valid), 32'(v));
        chk({tag, ".pend_cnt"},  32'(pend_cnt),  32'(c));
        chk({tag, ".overflow"},  32'(overflow),  32'(o));
        chk({tag, ".armed"},     32'(armed),     32'(a));
    endtask

    initial begin
        int seq32 [4];
        int exp_c;

        // First change arrives, counted two edges after its capture edge.
        vecs[0] = '{1'b0, 1'b0, 2, 1'b0, 0, 1'b0, 1'b1};
        vecs[1] = '{1'b0, 1'b0, 1, 1'b1, 1, 1'b0, 1'b1};
        vecs[2] = '{1'b0, 1'b0, 3, 1'b1, 1, 1'b0, 1'b1};
        // Opposite polarity six cycles after the first change.
        vecs[3] = '{1'b1, 1'b0, 2, 1'b1, 1, 1'b0, 1'b1};
        vecs[4] = '{1'b1, 1'b0, 1, 1'b1, 2, 1'b0, 1'b1};
        // Drain by accepts, then ready with nothing pending.
        vecs[5] = '{1'b1, 1'b1, 1, 1'b1, 1, 1'b0, 1'b1};
        vecs[6] = '{1'b1, 1'b1, 1, 1'b0, 0, 1'b0, 1'b1};
        vecs[7] = '{1'b1, 1'b1, 3, 1'b0, 0, 1'b0, 1'b1};
        vecs[8] = '{1'b1, 1'b0, 1, 1'b0, 0, 1'b0, 1'b1};
        seq32 = '{3, 2, 1, 0};

        rst       = 1'b1;
        tgl_in    = 1'b1;
        evt_ready = 1'b0;
        clr_ovf   = 1'b0;
        tick(3);
        chk_all("reset", 1'b0, 0, 1'b0, 1'b0);

        // Release with the line held high: warm-up only, no event.
        rst = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            tick(1);
            chk($sformatf("warmup%0d.armed", i), 32'(armed), 32'(i >= 4));
            chk($sformatf("warmup%0d.evt_valid", i), 32'(evt_valid), 32'(0));
        end
        chk("warmup.pend_cnt", 32'(pend_cnt), 32'(0));

        for (int i = 0; i < NVEC; i++) begin
            tgl_in    = vecs[i].tgl;
            evt_ready = vecs[i].rdy;
            tick(vecs[i].ticks);
            chk_all($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_cnt,
                    vecs[i].exp_ovf, vecs[i].exp_armed);
        end
        evt_ready = 1'b0;

        // Seventeen toggles with no consumer: saturate at 15 and flag overflow.
        for (int i = 0; i < 17; i++) begin
            tgl_in = ~tgl_in;
            tick(4);
            exp_c = (i + 1 > 15) ? 15 : i + 1;
            chk_all($sformatf("sat%0d", i), 1'b1, exp_c, 1'b0 | (i + 1 > 15), 1'b1);
        end
        clr_ovf = 1'b1;
        tick(1);
        clr_ovf = 1'b0;
        chk_all("clr_ovf", 1'b1, 15, 1'b0, 1'b1);

        // Edge at max coinciding with an accept: no change, no overflow.
        tgl_in = ~tgl_in;
        tick(2);
        chk("max_pre.pend_cnt", 32'(pend_cnt), 32'(15));
        evt_ready = 1'b1;
        tick(1);
        evt_ready = 1'b0;
        chk_all("max_edge_acc", 1'b1, 15, 1'b0, 1'b1);
        tick(1);
        chk_all("max_edge_acc_next", 1'b1, 15, 1'b0, 1'b1);

        // Drain down to 3.
        evt_ready = 1'b1;
        tick(12);
        evt_ready = 1'b0;
        chk("drain3.pend_cnt", 32'(pend_cnt), 32'(3));

        // Edge and accept together at 3, then continuous accepts: 3,3,2,1,0.
        tgl_in = ~tgl_in;
        tick(2);
        chk_all("seq_pre", 1'b1, 3, 1'b0, 1'b1);
        evt_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            tick(1);
            chk_all($sformatf("seq%0d", j), 1'b0 | (seq32[j] != 0), seq32[j], 1'b0, 1'b1);
        end
        tick(1);
        chk_all("seq_hold0", 1'b0, 0, 1'b0, 1'b1);
        evt_ready = 1'b0;

        // Refill to max, then a saturating edge coinciding with clr_ovf.
        for (int i = 0; i < 15; i++) begin
            tgl_in = ~tgl_in;
            tick(4);
        end
        chk_all("refill", 1'b1, 15, 1'b0, 1'b1);
        tgl_in = ~tgl_in;
        tick(2);
        clr_ovf = 1'b1;
        tick(1);
        clr_ovf = 1'b0;
        chk_all("set_wins", 1'b1, 15, 1'b1, 1'b1);
        clr_ovf = 1'b1;
        tick(1);
        clr_ovf = 1'b0;
        chk_all("clr_after", 1'b1, 15, 1'b0, 1'b1);

        // Drain to 5, then a one-cycle reset with the line going high.
        evt_ready = 1'b1;
        tick(10);
        evt_ready = 1'b0;
        chk_all("drain5", 1'b1, 5, 1'b0, 1'b1);
        rst    = 1'b1;
        tgl_in = 1'b1;
        tick(1);
        rst = 1'b0;
        chk_all("midrst", 1'b0, 0, 1'b0, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            tick(1);
            chk($sformatf("rearm%0d.armed", i), 32'(armed), 32'(i >= 4));
        end
        tick(6);
        chk_all("post_rst_idle", 1'b0, 0, 1'b0, 1'b1);

        // Decoding works again after the re-arm.
        tgl_in = 1'b0;
        tick(2);
        chk("post_rst_evt_pre.pend_cnt", 32'(pend_cnt), 32'(0));
        tick(1);
        chk_all("post_rst_evt", 1'b1, 1, 1'b0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_toggle_event_rx
